md_sequencer: RTL and testbench
===============================

# md_sequencer

Multi-cycle multiply/divide sequencer that replaces the single-cycle combinational mult/div path feeding the Lo/Hi register. It accepts one operation per start pulse and runs an iterative shift-add multiplier or restoring divider over XLEN cycles. It returns a 64-bit {hi, lo} result with a done pulse. The control unit holds `busy` as a pipeline stall for mfhi/mflo and for any new mult/div.

## Interface
- XLEN, 32, operand width; the result is 2*XLEN.
- clk  input  1  clock, rising edge.
- rst  input  1  reset. Asynchronous, active-high; clears all state.
- start  input  1  request; sampled on the rising edge of clk.
- is_mult  input  1  1 = multiply, 0 = divide. Sampled with start.
- is_unsigned  input  1  1 = unsigned, 0 = two's-complement. Sampled with start.
- a  input  XLEN  multiplicand or dividend (rs).
- b  input  XLEN  multiplier or divisor (rt).
- busy  output  1  operation in flight; start is ignored while high.
- done  output  1  one-cycle pulse; result is valid from this cycle.
- result  output  2*XLEN  {hi, lo}. Held until the next accepted start completes.
- div_by_zero  output  1  valid with done; 1 when a divide had b == 0.

## Operation
- FSM states and transitions:
  - IDLE: start=1 → PREP. Latch a, b, is_mult, is_unsigned.
  - PREP: compute |a| and |b| when signed; record the result sign. Unsigned ops pass operands through. PREP → RUN; iteration counter = 0.
  - RUN, multiply: if multiplier LSB is 1, add the shifted multiplicand into the 2*XLEN accumulator. Then shift multiplicand left and multiplier right.
  - RUN, divide: restoring step. Shift {rem, quo} left by 1; trial-subtract the divisor; keep the difference and set the quotient bit when it is non-negative.
  - RUN: counter increments each cycle. Leave RUN → FIX after the XLEN-th iteration.
  - FIX: apply sign correction and load the result register. FIX → DONE.
  - DONE: done=1 for one cycle. start=1 → PREP; otherwise → IDLE.
- Sign rules:
  - Signed multiply: the product is negated when the operand signs differ. -2^31 * -2^31 = 0x4000_0000_0000_0000.
  - Signed divide: the quotient is negated when the signs differ; the remainder takes the dividend's sign.
  - -2^31 / -1 gives lo = 0x8000_0000, hi = 0 (wraps, no flag).
- Divide by zero (b == 0, either signedness): lo = all ones, hi = a, div_by_zero = 1. Latency is unchanged.
- div_by_zero is 0 for every multiply and for every divide with b ≠ 0.
- All arithmetic uses unsigned XLEN+1-bit trial subtraction and a 2*XLEN accumulator; there is no overflow output.
- Inputs a and b may change after the start edge; only the latched copies are used.

## Timing
- Reset values: busy=0, done=0, result=0, div_by_zero=0, state=IDLE.
- An asynchronous reset mid-operation aborts it immediately. No done is produced and result reads 0.
- start sampled at edge N:
  - busy=1 from cycle N+1 through FIX.
  - done=1 in cycle N+XLEN+3 (35 for XLEN=32), with busy=0.
- Back-to-back: start in the DONE cycle is accepted, so the next op begins PREP one cycle after done. Throughput is one op per XLEN+3 cycles.
- start while busy=1 is dropped. There is no queuing and no error.
- result changes only at the FIX→DONE edge.

## Configuration
- MD_EARLY_TERM_EN defined:
  - Multiply leaves RUN at the first RUN cycle in which the remaining multiplier value is 0.
  - RUN length = max(1, position of the highest set bit of |b| + 1).
  - done arrives at N + 3 + that length. Divide timing is unchanged. Results are identical.
- Undefined: RUN is always XLEN cycles for every op, giving a fixed latency of XLEN+3.

## Test plan
- Unsigned mult, a=0xFFFF_FFFF, b=0xFFFF_FFFF → result=0xFFFF_FFFE_0000_0001 and done at N+35 (no MD_EARLY_TERM_EN).
- Signed mult, a=-7, b=3 → result=0xFFFF_FFFF_FFFF_FFEB. Signed div, a=-7, b=2 → lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1).
- Div by zero, a=0x1234, b=0, is_unsigned=1 → lo=0xFFFF_FFFF, hi=0x1234, div_by_zero=1 with done. Signed -2^31 / -1 → lo=0x8000_0000, hi=0.
- Second start at N+5 during a busy op → ignored, exactly one done. A start in the DONE cycle → next done 35 cycles later.
- rst asserted mid-RUN, between clock edges → busy/done/result drop to 0 immediately. A new start after release completes normally.
- With MD_EARLY_TERM_EN: unsigned mult a=5, b=3 → result=15, done at N+5. b=0 → result=0, done at N+4. Div timing still N+35.

Source files
------------

// File: rtl/md_sequencer.sv
// md_sequencer: iterative shift-add multiplier / restoring divider producing {hi, lo}.
// Optional feature MD_EARLY_TERM_EN: multiply leaves RUN once the remaining multiplier is zero.
module md_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_mult,
    input  logic              is_unsigned,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic              busy,
    output logic              done,
    output logic [2*XLEN-1:0] result,
    output logic              div_by_zero
);
    localparam int unsigned RW = 2 * XLEN;
    localparam int unsigned CW = $clog2(XLEN);

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE} state_t;

    state_t          state, state_nx;
    logic [XLEN-1:0] a_q, b_q, opb;
    logic [RW-1:0]   acc, opa;
    logic [CW-1:0]   cnt;
    logic            op_mult, op_uns, neg_res, neg_rem;

    logic [XLEN-1:0] a_abs, b_abs, div_diff, quo_fix, rem_fix;
    logic [XLEN:0]   div_sh;
    logic [RW-1:0]   fix_val;
    logic            div_ge, last_iter, accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        last_iter = (cnt == CW'(XLEN - 1));
`ifdef MD_EARLY_TERM_EN
        if (op_mult && (opb[XLEN-1:1] == '0)) last_iter = 1'b1;
`endif
        case (state)
            S_IDLE:  if (start) state_nx = S_PREP;
            S_PREP:  state_nx = S_RUN;
            S_RUN:   if (last_iter) state_nx = S_FIX;
            S_FIX:   state_nx = S_DONE;
            S_DONE:  state_nx = start ? S_PREP : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Operand magnitudes, one restoring-divide step and the final sign fix-up
    always_comb begin
        accept   = start && ((state == S_IDLE) || (state == S_DONE));
        a_abs    = (!op_uns && a_q[XLEN-1]) ? XLEN'(-a_q) : a_q;
        b_abs    = (!op_uns && b_q[XLEN-1]) ? XLEN'(-b_q) : b_q;
        div_sh   = {acc[RW-1:XLEN], acc[XLEN-1]};
        div_ge   = (div_sh >= {1'b0, opb});
        div_diff = XLEN'(div_sh - {1'b0, opb});
        quo_fix  = neg_res ? XLEN'(-acc[XLEN-1:0]) : acc[XLEN-1:0];
        rem_fix  = neg_rem ? XLEN'(-acc[RW-1:XLEN]) : acc[RW-1:XLEN];
        if (op_mult)          fix_val = neg_res ? RW'(-acc) : acc;
        else if (b_q == '0)   fix_val = {a_q, {XLEN{1'b1}}};
        else                  fix_val = {rem_fix, quo_fix};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_mult     <= 1'b0;
            op_uns      <= 1'b0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            acc         <= '0;
            opa         <= '0;
            opb         <= '0;
            cnt         <= '0;
        end else begin
            busy <= (state_nx == S_PREP) || (state_nx == S_RUN) || (state_nx == S_FIX);
            done <= (state_nx == S_DONE);
            if (accept) begin
                a_q     <= a;
                b_q     <= b;
                op_mult <= is_mult;
                op_uns  <= is_unsigned;
            end
            case (state)
                S_PREP: begin
                    cnt     <= '0;
                    neg_res <= !op_uns && (a_q[XLEN-1] ^ b_q[XLEN-1]);
                    neg_rem <= !op_uns && a_q[XLEN-1];
                    opb     <= b_abs;
                    if (op_mult) begin
                        acc <= '0;
                        opa <= RW'(a_abs);
                    end else begin
                        acc <= RW'(a_abs);
                        opa <= '0;
                    end
                end
                S_RUN: begin
                    cnt <= cnt + CW'(1);
                    if (op_mult) begin
                        if (opb[0]) acc <= acc + opa;
                        opa <= opa << 1;
                        opb <= opb >> 1;
                    end else begin
                        // acc holds {remainder, quotient}; quotient bits enter at the LSB
                        acc <= {(div_ge ? div_diff : div_sh[XLEN-1:0]), acc[XLEN-2:0], div_ge};
                    end
                end
                S_FIX: begin
                    result      <= fix_val;
                    div_by_zero <= !op_mult && (b_q == '0);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: directed vector table, multi-cycle corner sequences and random ops
// checked against an arithmetic reference model of md_sequencer.
module tb_md_sequencer;
    logic        clk = 1'b0;
    logic        rst, start, is_mult, is_unsigned;
    logic [31:0] a, b;
    logic        busy, done, div_by_zero;
    logic [63:0] result;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        m;
        logic        u;
        logic [31:0] av;
        logic [31:0] bv;
        logic [63:0] res;
        logic        dbz;
    } vec_t;

    md_sequencer #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .is_mult(is_mult), .is_unsigned(is_unsigned),
        .a(a), .b(b), .busy(busy), .done(done), .result(result), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: {div_by_zero, result} from plain 64-bit arithmetic
    function automatic logic [64:0] ref_op(input logic m, input logic u,
                                           input logic [31:0] av, input logic [31:0] bv);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, up;
        logic [63:0]     r;
        sa = $signed(av);
        sb = $signed(bv);
        ua = av;
        ub = bv;
        if (m) begin
            if (u) begin up = ua * ub; r = up; end
            else   begin sq = sa * sb; r = sq; end
            return {1'b0, r};
        end
        if (bv == 32'd0) return {1'b1, av, 32'hFFFF_FFFF};
        if (u) r = {32'(ua % ub), 32'(ua / ub)};
        else begin
            sq = sa / sb;
            sr = sa % sb;
            r  = {32'(sr), 32'(sq)};
        end
        return {1'b0, r};
    endfunction

    // Reference: cycle (relative to the start edge) in which done is high
    function automatic int ref_lat(input logic m, input logic u, input logic [31:0] bv);
        int          len;
        logic [31:0] mag;
        mag = (!u && bv[31]) ? 32'(-bv) : bv;
        len = 1;
        for (int i = 0; i < 32; i++) if (mag[i]) len = i + 1;
`ifndef MD_EARLY_TERM_EN
        len = 32;
`endif
        return m ? 3 + len : 35;
    endfunction

    task automatic wait_done(output int k);
        k = 0;
        while (!done && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic do_op(input logic m, input logic u, input logic [31:0] av, input logic [31:0] bv,
                         output logic [63:0] r, output logic z, output int lat);
        int k;
        @(posedge clk); #1;
        start = 1'b1; is_mult = m; is_unsigned = u; a = av; b = bv;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
        chk("busy_after_start", 64'(busy), 64'd1);
        wait_done(k);
        lat = k + 1;
        chk("busy_at_done", 64'(busy), 64'd0);
        r = result;
        z = div_by_zero;
        @(posedge clk); #1;
        chk("done_one_cycle", 64'(done), 64'd0);
    endtask

    initial begin
        vec_t        vecs[12];
        logic [63:0] r;
        logic        z;
        int          lat, k, ndone;
        logic [64:0] exp;
        logic        m, u;
        logic [31:0] av, bv;

        rst = 1'b1; start = 1'b0; is_mult = 1'b0; is_unsigned = 1'b0; a = '0; b = '0;
        vecs[0]  = '{1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'hFFFF_FFF9, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 32'h0000_1234, 32'h0000_0000, 64'h0000_1234_FFFF_FFFF, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 32'h0000_0005, 32'h0000_0003, 64'h0000_0000_0000_000F, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 32'h1234_5678, 32'h0000_0000, 64'h0000_0000_0000_0000, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 32'hFFFF_FFF9, 32'h0000_0000, 64'hFFFF_FFF9_FFFF_FFFF, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 32'h0000_0064, 32'h0000_0007, 64'h0000_0002_0000_000E, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_result", result, 64'd0);
        chk("reset_dbz", 64'(div_by_zero), 64'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            do_op(vecs[i].m, vecs[i].u, vecs[i].av, vecs[i].bv, r, z, lat);
            chk($sformatf("vec%0d_result", i), r, vecs[i].res);
            chk($sformatf("vec%0d_dbz", i), 64'(z), 64'(vecs[i].dbz));
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(ref_lat(vecs[i].m, vecs[i].u, vecs[i].bv)));
        end

        // Start during a busy op is dropped: one done, first op's result
        @(posedge clk); #1;
        start = 1'b1; is_mult = 1'b0; is_unsigned = 1'b1; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; is_mult = 1'b1; a = 32'd3; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        r = '0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (done) begin ndone++; r = result; end
        end
        chk("busy_start_ndone", 64'(ndone), 64'd1);
        chk("busy_start_result", r, {32'd2, 32'd14});
        chk("busy_start_idle", 64'(busy), 64'd0);

        // Start in the DONE cycle is accepted; next done a full latency later
        @(posedge clk); #1;
        start = 1'b1; is_mult = 1'b0; is_unsigned = 1'b0; a = 32'hFFFF_FF9C; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(k);
        chk("b2b_first_lat", 64'(k + 1), 64'd35);
        chk("b2b_first_result", result, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
        start = 1'b1; is_unsigned = 1'b1; a = 32'd1000; b = 32'd10;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_second_busy", 64'(busy), 64'd1);
        wait_done(k);
        chk("b2b_second_lat", 64'(k + 1), 64'd35);
        chk("b2b_second_result", result, {32'd0, 32'd100});
        @(posedge clk); #1;

        // Asynchronous reset in the middle of RUN
        start = 1'b1; is_mult = 1'b1; is_unsigned = 1'b1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("midrun_busy", 64'(busy), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op(1'b1, 1'b1, 32'h0001_0000, 32'h0001_0000, r, z, lat);
        chk("post_rst_result", r, 64'h0000_0001_0000_0000);
        chk("post_rst_latency", 64'(lat), 64'(ref_lat(1'b1, 1'b1, 32'h0001_0000)));

        // Random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            m  = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            av = $urandom;
            case ($urandom_range(0, 3))
                0:       bv = 32'd0;
                1:       bv = 32'($urandom_range(0, 255));
                2:       bv = 32'(-$urandom_range(1, 255));
                default: bv = $urandom;
            endcase
            do_op(m, u, av, bv, r, z, lat);
            exp = ref_op(m, u, av, bv);
            chk($sformatf("rand%0d_result m=%0b u=%0b a=%h b=%h", i, m, u, av, bv), r, exp[63:0]);
            chk($sformatf("rand%0d_dbz", i), 64'(z), 64'(exp[64]));
            chk($sformatf("rand%0d_latency", i), 64'(lat), 64'(ref_lat(m, u, bv)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
